// File: rtl/calc_scheduler.sv
// ----------------------------------------------------------------------------
// calc_scheduler
//
// Purpose:
//   Sequences one arithmetic operation at a time onto three external
//   functional units: multiplier (MUL), divider (DIV) and square root (RAIZ).
//   An accepted request latches its operands, fires a one-cycle start pulse to
//   the selected unit, then waits for that unit's completion flag. It captures
//   the unit's result and waits for the flag to drop again before it reports
//   completion. Each wait phase is bounded by TIMEOUT cycles. Illegal requests
//   (reserved opcode, divide by zero) complete immediately with ERR set, and
//   no unit is started.
//
// Parameters:
//   WIDTH    operand width in bits
//   TIMEOUT  maximum number of cycles spent in each wait phase (>= 1)
//
// Ports:
//   CLK        in   1        clock, rising edge
//   RST        in   1        synchronous reset, active high
//   START      in   1        operation request, sampled only while idle
//   OP         in   2        00 MUL, 01 DIV, 10 RAIZ, 11 reserved
//   A, B       in   WIDTH    operands (B unused by RAIZ)
//   OPA, OPB   out  WIDTH    latched operands shared by all units
//   INIT_MUL   out  1        start pulse, multiplier
//   INIT_DIV   out  1        start pulse, divider
//   INIT_RAIZ  out  1        start pulse, square root
//   DONE_MUL   in   1        multiplier completion flag (may stay high)
//   DONE_DIV   in   1        divider completion flag (may stay high)
//   DONE_RAIZ  in   1        square root completion flag (may stay high)
//   RES_MUL    in   2*WIDTH  product
//   RES_DIV    in   WIDTH    quotient
//   RES_RAIZ   in   WIDTH    root
//   RESULT     out  2*WIDTH  captured result, held until the next capture
//   BUSY       out  1        high in every state except IDLE
//   DONE       out  1        one-cycle completion pulse
//   ERR        out  1        error flag of the last operation
// ----------------------------------------------------------------------------
module calc_scheduler #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [1:0]           OP,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     OPA,
    output logic [WIDTH-1:0]     OPB,
    output logic                 INIT_MUL,
    output logic                 INIT_DIV,
    output logic                 INIT_RAIZ,
    input  logic                 DONE_MUL,
    input  logic                 DONE_DIV,
    input  logic                 DONE_RAIZ,
    input  logic [2*WIDTH-1:0]   RES_MUL,
    input  logic [WIDTH-1:0]     RES_DIV,
    input  logic [WIDTH-1:0]     RES_RAIZ,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_RAIZ = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    // The counter runs 0 .. TIMEOUT-1, so one wait phase lasts at most
    // TIMEOUT cycles before it is aborted.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RELEASE,
        FINISH
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [CNT_W-1:0]    cnt;
    logic                sel_done;
    logic [2*WIDTH-1:0]  sel_res;

    // Completion flag and result of the unit chosen by the latched opcode.
    // The other units' flags never reach the FSM, so they cannot disturb it.
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        case (op_q)
            OP_MUL: begin
                sel_done = DONE_MUL;
                sel_res  = RES_MUL;
            end
            OP_DIV: begin
                sel_done = DONE_DIV;
                sel_res  = {{WIDTH{1'b0}}, RES_DIV};
            end
            OP_RAIZ: begin
                sel_done = DONE_RAIZ;
                sel_res  = {{WIDTH{1'b0}}, RES_RAIZ};
            end
            default: begin
                sel_done = 1'b0;
                sel_res  = '0;
            end
        endcase
    end

    // Scheduler FSM. All outputs are registered: INIT_x and DONE are set on
    // the edge that enters LAUNCH / FINISH, so each is high for exactly the
    // one cycle spent in that state. LAUNCH ignores the completion flags, so
    // a flag left high by an earlier operation is not taken as completion
    // before the unit has seen its start pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            op_q      <= OP_MUL;
            cnt       <= '0;
            OPA       <= '0;
            OPB       <= '0;
            INIT_MUL  <= 1'b0;
            INIT_DIV  <= 1'b0;
            INIT_RAIZ <= 1'b0;
            RESULT    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            INIT_MUL  <= 1'b0;
            INIT_DIV  <= 1'b0;
            INIT_RAIZ <= 1'b0;
            DONE      <= 1'b0;

            case (state)
                IDLE: begin
                    if (START) begin
                        op_q <= OP;
                        OPA  <= A;
                        OPB  <= B;
                        cnt  <= '0;
                        BUSY <= 1'b1;
                        if (OP == OP_RSV || (OP == OP_DIV && B == '0)) begin
                            ERR   <= 1'b1;
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            ERR       <= 1'b0;
                            INIT_MUL  <= (OP == OP_MUL);
                            INIT_DIV  <= (OP == OP_DIV);
                            INIT_RAIZ <= (OP == OP_RAIZ);
                            state     <= LAUNCH;
                        end
                    end
                end

                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (sel_done) begin
                        RESULT <= sel_res;
                        cnt    <= '0;
                        state  <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        ERR   <= 1'b1;
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold off completion until the unit drops its flag, so a
                // flag that stays high cannot be seen as a second completion.
                RELEASE: begin
                    if (!sel_done) begin
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else if (cnt == CNT_LAST) begin
                        ERR   <= 1'b1;
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // START is deliberately not sampled here; a request present
                // now is taken on the following cycle in IDLE.
                FINISH: begin
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_scheduler.sv
// ----------------------------------------------------------------------------
// tb_calc_scheduler
//
// Purpose:
//   Self-checking bench for calc_scheduler. The bench plays the part of the
//   three functional units by driving the DONE_x / RES_x inputs on a
//   per-cycle schedule. Expected result/error pairs are pushed to a
//   scoreboard queue when a request is issued and popped when the DUT
//   pulses DONE.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_calc_scheduler;

    localparam int W  = 16;
    localparam int TO = 255;

    logic             CLK;
    logic             RST;
    logic             START;
    logic [1:0]       OP;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     OPA;
    logic [W-1:0]     OPB;
    logic             INIT_MUL;
    logic             INIT_DIV;
    logic             INIT_RAIZ;
    logic             DONE_MUL;
    logic             DONE_DIV;
    logic             DONE_RAIZ;
    logic [2*W-1:0]   RES_MUL;
    logic [W-1:0]     RES_DIV;
    logic [W-1:0]     RES_RAIZ;
    logic [2*W-1:0]   RESULT;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    // Observations collected while one request runs; cycle numbers count
    // from the accept cycle 0.
    typedef struct packed {
        int             n_init_mul;
        int             n_init_div;
        int             n_init_raiz;
        int             first_init;
        int             second_init;
        int             n_done;
        int             done_cyc;
        int             opab_bad;
        logic [2*W-1:0] res_k1;
        logic [2*W-1:0] res_done;
        logic           err_done;
        logic           err_c1;
        logic           busy_after;
    } obs_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [2*W-1:0] model_result;

    calc_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .OPA       (OPA),
        .OPB       (OPB),
        .INIT_MUL  (INIT_MUL),
        .INIT_DIV  (INIT_DIV),
        .INIT_RAIZ (INIT_RAIZ),
        .DONE_MUL  (DONE_MUL),
        .DONE_DIV  (DONE_DIV),
        .DONE_RAIZ (DONE_RAIZ),
        .RES_MUL   (RES_MUL),
        .RES_DIV   (RES_DIV),
        .RES_RAIZ  (RES_RAIZ),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        START = 1'b0;
        DONE_MUL = 1'b0; DONE_DIV = 1'b0; DONE_RAIZ = 1'b0;
        tick();
        RST = 1'b0;
        model_result = '0;
    endtask

    // Issues one request (START in cycle 0) and emulates the selected unit:
    // its flag is high for cycles rise..fall-1, plus cycle 1 if glitch is set.
    // Optionally toggles the unselected flags and keeps START held high.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int unit,
                          input int rise, input int fall, input bit glitch,
                          input bit toggle_other, input bit hold_start,
                          output obs_t o);
        logic d;
        logic t;
        o             = '0;
        o.first_init  = -1;
        o.second_init = -1;
        o.done_cyc    = -1;
        OP = op; A = a; B = b; START = 1'b1;
        DONE_MUL = 1'b0; DONE_DIV = 1'b0; DONE_RAIZ = 1'b0;
        tick();
        for (int c = 1; c <= 400; c++) begin
            d = ((c >= rise && c < fall) || (glitch && c == 1));
            t = toggle_other && (c % 2 == 1);
            START     = hold_start;
            DONE_MUL  = (unit == 0) ? d : t;
            DONE_DIV  = (unit == 1) ? d : t;
            DONE_RAIZ = (unit == 2) ? d : t;
            if (INIT_MUL || INIT_DIV || INIT_RAIZ) begin
                if (o.first_init < 0) o.first_init = c;
                else if (o.second_init < 0) o.second_init = c;
            end
            if (o.done_cyc < 0 || c <= o.done_cyc + 1) begin
                if (INIT_MUL)  o.n_init_mul++;
                if (INIT_DIV)  o.n_init_div++;
                if (INIT_RAIZ) o.n_init_raiz++;
                if (OPA !== a || OPB !== b) o.opab_bad++;
            end
            if (c == 1) o.err_c1 = ERR;
            if (c == rise + 1) o.res_k1 = RESULT;
            if (DONE === 1'b1) begin
                o.n_done++;
                if (o.done_cyc < 0) begin
                    o.done_cyc = c;
                    o.res_done = RESULT;
                    o.err_done = ERR;
                end
            end
            if (o.done_cyc > 0 && c == o.done_cyc + 1) o.busy_after = BUSY;
            tick();
            if (o.done_cyc > 0 && c >= o.done_cyc + 3) break;
        end
        START = 1'b0;
        DONE_MUL = 1'b0; DONE_DIV = 1'b0; DONE_RAIZ = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b1; OP = 2'b00; A = 16'hAAAA; B = 16'h5555;
        DONE_MUL = 1'b0; DONE_DIV = 1'b0; DONE_RAIZ = 1'b0;
        RES_MUL = '0; RES_DIV = '0; RES_RAIZ = '0;
        tick();
        tick();
        n_checks++;
        if ({INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE, ERR} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE, ERR});
        else n_pass++;
        n_checks++;
        if (RESULT !== '0 || OPA !== '0 || OPB !== '0)
            $display("[TB] FAIL reset_data: got RESULT=%h OPA=%h OPB=%h expected all 0", RESULT, OPA, OPB);
        else n_pass++;
        RST = 1'b0; START = 1'b0;
        tick();
        n_checks++;
        if ({INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE} !== 5'b0)
            $display("[TB] FAIL reset_release: got %b expected 00000",
                     {INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE});
        else n_pass++;
        model_result = '0;
    endtask

    task automatic test_mul();
        obs_t o;
        exp_t e;
        RES_MUL = 32'd60000; RES_DIV = 16'h1111; RES_RAIZ = 16'h2222;
        model_result = 32'd60000;
        sb.push_back('{res: model_result, err: 1'b0});
        run_op(2'b00, 16'd300, 16'd200, 0, 5, 7, 1'b0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.n_init_mul !== 1 || o.first_init !== 1)
            $display("[TB] FAIL mul_init: got count=%0d first=%0d expected count=1 first=1", o.n_init_mul, o.first_init);
        else n_pass++;
        n_checks++;
        if (o.n_init_div !== 0 || o.n_init_raiz !== 0)
            $display("[TB] FAIL mul_other_init: got div=%0d raiz=%0d expected 0 0", o.n_init_div, o.n_init_raiz);
        else n_pass++;
        n_checks++;
        if (o.res_k1 !== 32'd60000)
            $display("[TB] FAIL mul_result_cycle6: got %0d expected 60000", o.res_k1);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 8 || o.n_done !== 1)
            $display("[TB] FAIL mul_done_cycle: got cycle=%0d count=%0d expected cycle=8 count=1", o.done_cyc, o.n_done);
        else n_pass++;
        n_checks++;
        if (o.busy_after !== 1'b0 || o.opab_bad !== 0)
            $display("[TB] FAIL mul_busy_opab: got busy=%b opab_bad=%0d expected 0 0", o.busy_after, o.opab_bad);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL mul_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL mul_scoreboard: got no DONE expected DONE");
    endtask

    task automatic test_div_interference();
        obs_t o;
        exp_t e;
        RES_MUL = 32'hFFFF_FFFF; RES_DIV = 16'hF00D; RES_RAIZ = 16'hBEEF;
        model_result = 32'h0000_F00D;
        sb.push_back('{res: model_result, err: 1'b0});
        run_op(2'b01, 16'd100, 16'd7, 1, 6, 8, 1'b0, 1'b1, 1'b0, o);
        n_checks++;
        if (o.n_init_div !== 1 || o.n_init_mul !== 0 || o.n_init_raiz !== 0)
            $display("[TB] FAIL div_init: got mul=%0d div=%0d raiz=%0d expected 0 1 0", o.n_init_mul, o.n_init_div, o.n_init_raiz);
        else n_pass++;
        n_checks++;
        if (o.res_k1 !== 32'h0000_F00D)
            $display("[TB] FAIL div_zero_extend: got %h expected 0000f00d", o.res_k1);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 9)
            $display("[TB] FAIL div_done_cycle: got %0d expected 9", o.done_cyc);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL div_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL div_scoreboard: got no DONE expected DONE");
    endtask

    task automatic test_raiz_held();
        obs_t o;
        exp_t e;
        RES_MUL = 32'hDEAD_BEEF; RES_DIV = 16'h3333; RES_RAIZ = 16'd12;
        model_result = 32'd12;
        sb.push_back('{res: model_result, err: 1'b0});
        run_op(2'b10, 16'd144, 16'h5555, 2, 4, 35, 1'b0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.n_init_raiz !== 1 || o.second_init !== -1)
            $display("[TB] FAIL raiz_relaunch: got count=%0d second=%0d expected 1 -1", o.n_init_raiz, o.second_init);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 36 || o.n_done !== 1)
            $display("[TB] FAIL raiz_done: got cycle=%0d count=%0d expected cycle=36 count=1", o.done_cyc, o.n_done);
        else n_pass++;
        n_checks++;
        if (o.opab_bad !== 0)
            $display("[TB] FAIL raiz_opab: got %0d bad cycles expected 0", o.opab_bad);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL raiz_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL raiz_scoreboard: got no DONE expected DONE");
    endtask

    task automatic test_launch_glitch();
        obs_t o;
        exp_t e;
        RES_MUL = 32'h1234_5678; RES_DIV = 16'h0; RES_RAIZ = 16'h0;
        model_result = 32'h1234_5678;
        sb.push_back('{res: model_result, err: 1'b0});
        run_op(2'b00, 16'd5, 16'd9, 0, 4, 6, 1'b1, 1'b0, 1'b0, o);
        n_checks++;
        if (o.done_cyc !== 7)
            $display("[TB] FAIL glitch_done_cycle: got %0d expected 7", o.done_cyc);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL glitch_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL glitch_scoreboard: got no DONE expected DONE");
    endtask

    task automatic test_illegal(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        obs_t o;
        exp_t e;
        sb.push_back('{res: model_result, err: 1'b1});
        run_op(op, a, b, 1, 1000, 1001, 1'b0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.first_init !== -1)
            $display("[TB] FAIL illegal_no_init op=%b: got init at cycle %0d expected none", op, o.first_init);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 1)
            $display("[TB] FAIL illegal_done_cycle op=%b: got %0d expected 1", op, o.done_cyc);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL illegal_scoreboard op=%b: got res=%h err=%b expected res=%h err=%b", op, o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL illegal_scoreboard op=%b: got no DONE expected DONE", op);
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back('{res: model_result, err: 1'b1});
        run_op(2'b01, 16'd9, 16'd3, 1, 10000, 10001, 1'b0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.err_c1 !== 1'b0)
            $display("[TB] FAIL timeout_err_cleared: got %b expected 0", o.err_c1);
        else n_pass++;
        n_checks++;
        if (o.done_cyc !== 2 + TO || o.n_init_div !== 1)
            $display("[TB] FAIL timeout_done_cycle: got cycle=%0d init=%0d expected cycle=%0d init=1", o.done_cyc, o.n_init_div, 2 + TO);
        else n_pass++;
        n_checks++;
        if (o.busy_after !== 1'b0)
            $display("[TB] FAIL timeout_busy_after: got %b expected 0", o.busy_after);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL timeout_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL timeout_scoreboard: got no DONE expected DONE");
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        stray = 0;
        OP = 2'b00; A = 16'd5; B = 16'd6; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        n_checks++;
        if (RESULT !== model_result || BUSY !== 1'b1)
            $display("[TB] FAIL rst_pre_state: got RESULT=%h BUSY=%b expected RESULT=%h BUSY=1", RESULT, BUSY, model_result);
        else n_pass++;
        RST = 1'b1; START = 1'b1;
        tick();
        RST = 1'b0; START = 1'b0;
        n_checks++;
        if ({INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE, ERR} !== 6'b0)
            $display("[TB] FAIL rst_mid_flags: got %b expected 000000",
                     {INIT_MUL, INIT_DIV, INIT_RAIZ, BUSY, DONE, ERR});
        else n_pass++;
        n_checks++;
        if (RESULT !== '0 || OPA !== '0 || OPB !== '0)
            $display("[TB] FAIL rst_mid_data: got RESULT=%h OPA=%h OPB=%h expected all 0", RESULT, OPA, OPB);
        else n_pass++;
        model_result = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (INIT_MUL || INIT_DIV || INIT_RAIZ || BUSY || DONE) stray++;
        end
        n_checks++;
        if (stray !== 0)
            $display("[TB] FAIL rst_mid_quiet: got %0d active cycles expected 0", stray);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        RES_MUL = 32'd12; RES_DIV = 16'h0; RES_RAIZ = 16'h0;
        model_result = 32'd12;
        sb.push_back('{res: model_result, err: 1'b0});
        run_op(2'b00, 16'd3, 16'd4, 0, 3, 4, 1'b0, 1'b0, 1'b1, o);
        n_checks++;
        if (o.n_init_mul !== 1 || o.done_cyc !== 5)
            $display("[TB] FAIL b2b_single_launch: got init=%0d done=%0d expected init=1 done=5", o.n_init_mul, o.done_cyc);
        else n_pass++;
        n_checks++;
        if (o.busy_after !== 1'b0)
            $display("[TB] FAIL b2b_idle_gap: got busy=%b expected 0", o.busy_after);
        else n_pass++;
        n_checks++;
        if (o.second_init !== 7)
            $display("[TB] FAIL b2b_second_init: got cycle %0d expected 7", o.second_init);
        else n_pass++;
        n_checks++;
        if (o.done_cyc > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            if (o.res_done !== e.res || o.err_done !== e.err)
                $display("[TB] FAIL b2b_scoreboard: got res=%h err=%b expected res=%h err=%b", o.res_done, o.err_done, e.res, e.err);
            else n_pass++;
        end else $display("[TB] FAIL b2b_scoreboard: got no DONE expected DONE");
        do_reset();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_interference();
        test_raiz_held();
        test_launch_glitch();
        test_illegal(2'b01, 16'd7, 16'd0);
        test_illegal(2'b11, 16'd7, 16'd2);
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0)
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_scheduler.md
CALC_SCHEDULER -- requirements
Module: calc_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles per wait phase before abort.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, with these ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  operation request, level-sampled in IDLE.
- OP  input  2  opcode: 00 MUL, 01 DIV, 10 RAIZ, 11 reserved.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored for RAIZ).
- OPA  output  WIDTH  registered A, presented to all units.
- OPB  output  WIDTH  registered B, presented to all units.
- INIT_MUL, INIT_DIV, INIT_RAIZ  output  1 each  unit start pulses.
- DONE_MUL, DONE_DIV, DONE_RAIZ  input  1 each  unit completion flags; a flag may stay high for many cycles.
- RES_MUL  input  2*WIDTH  product.
- RES_DIV  input  WIDTH  quotient.
- RES_RAIZ  input  WIDTH  root.
- RESULT  output  2*WIDTH  captured result.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  error flag for the last operation.

Function
REQ-004 The FSM SHALL have the states IDLE, LAUNCH, WAIT, RELEASE and FINISH.
REQ-005 In IDLE with START=1, the block SHALL latch OP, A and B into internal registers and into OPA/OPB, and clear ERR.
REQ-006 From IDLE with START=1, the next state SHALL be:
- FINISH with ERR set, if OP=11, or if OP=01 and B=0;
- LAUNCH otherwise.
REQ-007 In LAUNCH, the block SHALL assert exactly one INIT_x (the one selected by the latched OP) for exactly one cycle, clear the cycle counter, and go to WAIT.
REQ-008 In WAIT, the block SHALL increment the counter each cycle and sample only the DONE_x of the selected unit.
REQ-009 In WAIT with selected DONE_x=1, the block SHALL capture RESULT and go to RELEASE with the counter cleared. RESULT is formed as:
- RES_MUL as-is;
- RES_DIV zero-extended to 2*WIDTH;
- RES_RAIZ zero-extended to 2*WIDTH.
REQ-010 In WAIT, if the counter reaches TIMEOUT with no DONE_x, the block SHALL set ERR, leave RESULT unchanged, and go to FINISH.
REQ-011 In RELEASE, the block SHALL wait for the selected DONE_x to return to 0 and then go to FINISH; if the counter reaches TIMEOUT first, it SHALL set ERR (RESULT kept) and go to FINISH.
REQ-012 In FINISH, the block SHALL assert DONE for one cycle and return to IDLE.
REQ-013 For a unit whose DONE_x rises in cycle k (k≥2 after the accept cycle 0) and falls in cycle m, RESULT SHALL be valid from cycle k+1, and DONE SHALL pulse in cycle m+1.
REQ-014 START SHALL be ignored while BUSY=1; there is no queueing.
REQ-015 DONE_x already high during LAUNCH SHALL NOT be treated as completion; DONE_x of unselected units SHALL be ignored in all states.
REQ-016 OPA/OPB SHALL hold stable from the accept cycle until the next accepted START.
REQ-017 RESULT and ERR SHALL hold their values until the next accepted START (ERR) or the next capture (RESULT).
REQ-018 A START present in the same cycle that FINISH returns to IDLE SHALL be accepted on the following cycle (IDLE), not in FINISH.

Reset
REQ-019 While RST=1, on the next edge: state=IDLE, all INIT_x=0, BUSY=0, DONE=0, ERR=0, RESULT=0, OPA=0, OPB=0, counter=0.
REQ-020 RST SHALL override START and any in-flight operation; no INIT_x or DONE pulse SHALL be issued in the cycle following reset.

Verification
REQ-021 MUL: A=300, B=200, OP=00, DONE_MUL high cycles 5-6 -> INIT_MUL only in cycle 1, RESULT=60000 from cycle 6, DONE pulse cycle 8, ERR=0.
REQ-022 RAIZ with held DONE: A=144, OP=10, RES_RAIZ=12, DONE_RAIZ high for 31 cycles -> exactly one capture, RESULT=12, one DONE pulse after DONE_RAIZ falls, no re-launch.
REQ-023 DIV by zero: OP=01, A=7, B=0 -> no INIT_x ever asserted, ERR=1, DONE pulse in cycle 1, RESULT unchanged.
REQ-024 Timeout: OP=01, A=9, B=3, DONE_DIV never asserted, TIMEOUT=255 -> ERR=1 and DONE pulse after 255 WAIT cycles, BUSY=0 afterwards.
REQ-025 Reset mid-WAIT plus interference: RST pulsed during WAIT -> all outputs zero the next cycle. Toggling DONE_MUL during a DIV operation -> ignored. START held high during BUSY -> no second INIT_x until IDLE.
